packet_frame_ctrl: RTL and testbench
====================================

// Module: packet_frame_ctrl
// PURPOSE
//  Sequencer behind the per-byte symbol classifier. Owns the TLP/DLLP context register fed back to the classifier.
//  Tracks packet framing with an FSM, streams payload bytes to the packet buffer, then commits or discards each packet.
//  Publishes one-deep packet descriptors to the downstream parser over a valid/ready handshake.
// PARAMETERS
//  LEN_W    13    width of byte-length counter and pkt_len
//  MIN_TLP  18    min bytes STP..END, exclusive (seq 2 + hdr 12 + LCRC 4)
//  MAX_TLP  4112  max TLP bytes; reaching it aborts the packet
//  DLLP_LEN 6     exact DLLP bytes SDP..END, exclusive
//  ERR_W    8     error counter width
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      async active-low reset
//  in_valid     in   1      classifier output qualifies this cycle
//  in_type      in   3      000 data, 001 tlpstart, 010 tlpend, 011 dllpstart, 100 dllpend, 101 tlpedb, 111 not_valid
//  in_data      in   8      byte that accompanies in_type
//  ctx_next     in   2      classifier context output (00 none, 01 tlp, 10 dllp)
//  ctx_q        out  2      registered context driven back to the classifier's context input
//  buf_wr_en    out  1      write payload byte to buffer
//  buf_wr_data  out  8      payload byte
//  buf_commit   out  1      1-cycle pulse: keep the bytes written since the last start
//  buf_discard  out  1      1-cycle pulse: roll back the bytes written since the last start
//  pkt_valid    out  1      descriptor available
//  pkt_ready    in   1      downstream accepts descriptor
//  pkt_is_tlp   out  1      1 = TLP, 0 = DLLP
//  pkt_len      out  LEN_W  payload bytes in the packet
//  err_pulse    out  1      1-cycle pulse per detected error
//  err_cnt      out  ERR_W  saturating error count
// BEHAVIOUR
//  Reset: all outputs 0, ctx_q=00, FSM=IDLE, len=0. Reset mid-packet drops the partial packet with no discard pulse; the buffer is reset too.
//  ctx_q <= ctx_next on each in_valid=1 cycle; it holds otherwise. in_valid=0 or in_type=111 has no effect.
//  All outputs are registered, one cycle after the qualifying input. Start/end symbol bytes are never written.
//  IDLE: tlpstart -> TLP; dllpstart -> DLLP; len<=0 on either. tlpend/dllpend/tlpedb -> err, stay IDLE.
//  TLP: data -> buf_wr_en, len+1. If len+1 == MAX_TLP: discard, err, -> DROP.
//   tlpend: len>=MIN_TLP -> commit; otherwise discard + err. Either way -> IDLE.
//   tlpedb: discard, no err (nullified TLP), -> IDLE.
//   tlpstart/dllpstart: discard + err, restart as the new packet type with len<=0.
//  DLLP: data -> write, len+1. If len+1 > DLLP_LEN: discard, err, -> DROP.
//   dllpend: len==DLLP_LEN -> commit; otherwise discard + err. Either way -> IDLE.
//   tlpedb: discard + err, -> IDLE. Start symbols are handled as in TLP.
//  DROP: data is ignored. Any end/edb -> IDLE. Start symbols begin a new packet.
//  Commit loads the descriptor (is_tlp, len) and raises pkt_valid in the same cycle as buf_commit.
//  Handshake: a descriptor transfers when pkt_valid && pkt_ready; pkt_valid drops next cycle unless a new commit reloads it.
//  Commit while pkt_valid && !pkt_ready: the new packet is discarded (buf_discard instead of buf_commit), err raised, old descriptor held.
//  Commit in the same cycle as a handshake: the new descriptor loads and pkt_valid stays 1.
//  buf_commit and buf_discard never assert together. At most one err_pulse per cycle; err_cnt saturates at all-ones.
// TESTING
//  STP, 18 data 0x00..0x11, END: 18 wr pulses; commit 1 cycle after END; pkt_len=18, pkt_is_tlp=1; no err.
//  SDP, 6 data, END with pkt_ready=0, then STP, 20 data, END: second packet discarded; err_cnt=1; DLLP descriptor (len 6) held.
//  STP, 30 data, EDB: discard pulse, err_cnt unchanged; SDP, 5 data, END: discard, err_cnt=1.
//  STP, 10 data, SDP, 6 data, END: discard + err at SDP; the DLLP then commits with len 6; ctx_q follows ctx_next.
//  MAX_TLP=32; STP, 40 data, END: discard at byte 32, no writes for bytes 33..40, END -> IDLE, err_cnt=1.
//  Assert rst_n=0 mid-TLP (byte 7): outputs 0 asynchronously; after release, STP, 18 data, END commits with len 18.

Source files
------------

// File: rtl/packet_frame_ctrl.sv
`timescale 1ns/1ps
// Framing sequencer: tracks STP/SDP..END, streams payload to the buffer,
// commits or discards each packet and publishes a one-deep descriptor.
module packet_frame_ctrl #(
    parameter int LEN_W    = 13,
    parameter int MIN_TLP  = 18,
    parameter int MAX_TLP  = 4112,
    parameter int DLLP_LEN = 6,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       in_type,
    input  logic [7:0]       in_data,
    input  logic [1:0]       ctx_next,
    output logic [1:0]       ctx_q,
    output logic             buf_wr_en,
    output logic [7:0]       buf_wr_data,
    output logic             buf_commit,
    output logic             buf_discard,
    output logic             pkt_valid,
    input  logic             pkt_ready,
    output logic             pkt_is_tlp,
    output logic [LEN_W-1:0] pkt_len,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [2:0] T_DATA = 3'b000;
    localparam logic [2:0] T_STP  = 3'b001;
    localparam logic [2:0] T_TEND = 3'b010;
    localparam logic [2:0] T_SDP  = 3'b011;
    localparam logic [2:0] T_DEND = 3'b100;
    localparam logic [2:0] T_EDB  = 3'b101;
    localparam logic [2:0] T_NV   = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_TLP, S_DLLP, S_DROP} state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, len_inc;
    logic              act, wr_d, cmt_req, dis_req, err_req;
    logic              blocked, cmt_ok, dis_d, err_d;

    assign act     = in_valid && (in_type != T_NV);
    assign len_inc = len_q + 1'b1;
    assign blocked = pkt_valid && !pkt_ready;
    assign cmt_ok  = cmt_req && !blocked;
    // A good packet that cannot be published is rolled back as an error
    assign dis_d   = dis_req || (cmt_req && blocked);
    assign err_d   = err_req || (cmt_req && blocked);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wr_d    = 1'b0;
        cmt_req = 1'b0;
        dis_req = 1'b0;
        err_req = 1'b0;
        if (act) begin
            if (in_type == T_STP || in_type == T_SDP) begin
                if (state_q == S_TLP || state_q == S_DLLP) begin
                    dis_req = 1'b1;
                    err_req = 1'b1;
                end
                state_d = (in_type == T_STP) ? S_TLP : S_DLLP;
                len_d   = '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (in_type != T_DATA) err_req = 1'b1;
                    end
                    S_TLP: begin
                        if (in_type == T_DATA) begin
                            wr_d  = 1'b1;
                            len_d = len_inc;
                            if (len_inc == LEN_W'(MAX_TLP)) begin
                                dis_req = 1'b1;
                                err_req = 1'b1;
                                state_d = S_DROP;
                            end
                        end else begin
                            state_d = S_IDLE;
                            if (in_type == T_TEND && len_q >= LEN_W'(MIN_TLP))
                                cmt_req = 1'b1;
                            else begin
                                dis_req = 1'b1;
                                err_req = (in_type != T_EDB);
                            end
                        end
                    end
                    S_DLLP: begin
                        if (in_type == T_DATA) begin
                            wr_d  = 1'b1;
                            len_d = len_inc;
                            if (len_inc > LEN_W'(DLLP_LEN)) begin
                                dis_req = 1'b1;
                                err_req = 1'b1;
                                state_d = S_DROP;
                            end
                        end else begin
                            state_d = S_IDLE;
                            if (in_type == T_DEND && len_q == LEN_W'(DLLP_LEN))
                                cmt_req = 1'b1;
                            else begin
                                dis_req = 1'b1;
                                err_req = 1'b1;
                            end
                        end
                    end
                    S_DROP: begin
                        if (in_type != T_DATA) state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            ctx_q       <= 2'b00;
            buf_wr_en   <= 1'b0;
            buf_wr_data <= 8'h00;
            buf_commit  <= 1'b0;
            buf_discard <= 1'b0;
            pkt_valid   <= 1'b0;
            pkt_is_tlp  <= 1'b0;
            pkt_len     <= '0;
            err_pulse   <= 1'b0;
            err_cnt     <= '0;
        end else begin
            if (act) ctx_q <= ctx_next;
            state_q     <= state_d;
            len_q       <= len_d;
            buf_wr_en   <= wr_d;
            if (wr_d) buf_wr_data <= in_data;
            buf_commit  <= cmt_ok;
            buf_discard <= dis_d;
            err_pulse   <= err_d;
            if (err_d && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (cmt_ok) begin
                pkt_valid  <= 1'b1;
                pkt_is_tlp <= (state_q == S_TLP);
                pkt_len    <= len_q;
            end else if (pkt_ready) begin
                pkt_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_packet_frame_ctrl.sv
`timescale 1ns/1ps
// Directed bench for packet_frame_ctrl, built with MAX_TLP=32 so the
// abort path is reachable in a short run.
module tb_packet_frame_ctrl;

    localparam logic [2:0] T_DATA = 3'b000;
    localparam logic [2:0] T_STP  = 3'b001;
    localparam logic [2:0] T_TEND = 3'b010;
    localparam logic [2:0] T_SDP  = 3'b011;
    localparam logic [2:0] T_DEND = 3'b100;
    localparam logic [2:0] T_EDB  = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  in_type;
    logic [7:0]  in_data;
    logic [1:0]  ctx_next;
    logic [1:0]  ctx_q;
    logic        buf_wr_en;
    logic [7:0]  buf_wr_data;
    logic        buf_commit;
    logic        buf_discard;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        pkt_is_tlp;
    logic [12:0] pkt_len;
    logic        err_pulse;
    logic [7:0]  err_cnt;

    int checks = 0;
    int failures = 0;
    int wr_n, cmt_n, dis_n, errp_n, both_n;

    packet_frame_ctrl #(.MAX_TLP(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_type(in_type), .in_data(in_data),
        .ctx_next(ctx_next), .ctx_q(ctx_q),
        .buf_wr_en(buf_wr_en), .buf_wr_data(buf_wr_data),
        .buf_commit(buf_commit), .buf_discard(buf_discard),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_is_tlp(pkt_is_tlp), .pkt_len(pkt_len),
        .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wr_n = 0; cmt_n = 0; dis_n = 0; errp_n = 0;
    endtask

    task automatic tally();
        wr_n   += int'(buf_wr_en);
        cmt_n  += int'(buf_commit);
        dis_n  += int'(buf_discard);
        errp_n += int'(err_pulse);
        if (buf_commit && buf_discard) both_n++;
    endtask

    task automatic sym(input logic [2:0] t, input logic [7:0] d,
                       input logic [1:0] c);
        in_valid = 1'b1;
        in_type  = t;
        in_data  = d;
        ctx_next = c;
        @(posedge clk);
        #1;
        tally();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_type  = T_DATA;
        @(posedge clk);
        #1;
        tally();
    endtask

    task automatic data(input int n, input logic [1:0] c);
        for (int i = 0; i < n; i++) sym(T_DATA, 8'(i), c);
    endtask

    initial begin
        both_n = 0;
        clr();
        rst_n = 1'b0; in_valid = 1'b0; in_type = T_DATA;
        in_data = 8'h00; ctx_next = 2'b00; pkt_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_ctx", ctx_q, 0);
        chk("rst_wr_en", buf_wr_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Minimum-size TLP
        clr();
        sym(T_STP, 8'hFB, 2'b01);
        data(18, 2'b01);
        chk("t1_last_byte", buf_wr_data, 8'h11);
        sym(T_TEND, 8'hFD, 2'b00);
        chk("t1_commit_now", buf_commit, 1);
        chk("t1_wr_count", wr_n, 18);
        chk("t1_len", pkt_len, 18);
        chk("t1_is_tlp", pkt_is_tlp, 1);
        chk("t1_valid", pkt_valid, 1);
        chk("t1_err", err_cnt, 0);
        chk("t1_ctx", ctx_q, 0);
        pkt_ready = 1'b1;
        idle();
        chk("t1_hs_drop", pkt_valid, 0);
        pkt_ready = 1'b0;

        // DLLP held, following TLP blocked
        clr();
        sym(T_SDP, 8'h5C, 2'b10);
        data(6, 2'b10);
        sym(T_DEND, 8'hFD, 2'b00);
        chk("t2_dllp_commit", cmt_n, 1);
        clr();
        sym(T_STP, 8'hFB, 2'b01);
        data(20, 2'b01);
        sym(T_TEND, 8'hFD, 2'b00);
        chk("t2_blk_commit", cmt_n, 0);
        chk("t2_blk_discard", dis_n, 1);
        chk("t2_err", err_cnt, 1);
        chk("t2_held_len", pkt_len, 6);
        chk("t2_held_tlp", pkt_is_tlp, 0);
        chk("t2_held_valid", pkt_valid, 1);
        // Commit coinciding with handshake reloads descriptor
        clr();
        sym(T_STP, 8'hFB, 2'b01);
        data(19, 2'b01);
        pkt_ready = 1'b1;
        sym(T_TEND, 8'hFD, 2'b00);
        chk("t2_reload_commit", buf_commit, 1);
        chk("t2_reload_valid", pkt_valid, 1);
        chk("t2_reload_len", pkt_len, 19);
        chk("t2_reload_tlp", pkt_is_tlp, 1);
        chk("t2_reload_err", err_cnt, 1);
        idle();
        chk("t2_hs_drop", pkt_valid, 0);
        pkt_ready = 1'b0;

        // Nullified TLP, then short DLLP
        clr();
        sym(T_STP, 8'hFB, 2'b01);
        data(30, 2'b01);
        sym(T_EDB, 8'hFE, 2'b00);
        chk("t3_edb_discard", buf_discard, 1);
        chk("t3_edb_err", err_cnt, 1);
        clr();
        sym(T_SDP, 8'h5C, 2'b10);
        data(5, 2'b10);
        sym(T_DEND, 8'hFD, 2'b00);
        chk("t3_short_discard", dis_n, 1);
        chk("t3_short_commit", cmt_n, 0);
        chk("t3_err", err_cnt, 2);

        // Start inside a TLP restarts as a DLLP
        clr();
        sym(T_STP, 8'hFB, 2'b01);
        data(10, 2'b01);
        sym(T_SDP, 8'h5C, 2'b10);
        chk("t4_sdp_discard", buf_discard, 1);
        chk("t4_sdp_err", err_pulse, 1);
        chk("t4_ctx", ctx_q, 2);
        data(6, 2'b10);
        sym(T_DEND, 8'hFD, 2'b00);
        chk("t4_commit", buf_commit, 1);
        chk("t4_len", pkt_len, 6);
        chk("t4_is_tlp", pkt_is_tlp, 0);
        chk("t4_err", err_cnt, 3);
        pkt_ready = 1'b1;
        idle();
        pkt_ready = 1'b0;

        // Oversize TLP aborts at MAX_TLP
        clr();
        sym(T_STP, 8'hFB, 2'b01);
        data(31, 2'b01);
        chk("t5_no_early_dis", dis_n, 0);
        sym(T_DATA, 8'h1F, 2'b01);
        chk("t5_abort_discard", buf_discard, 1);
        data(8, 2'b01);
        sym(T_TEND, 8'hFD, 2'b00);
        chk("t5_wr_count", wr_n, 32);
        chk("t5_discards", dis_n, 1);
        chk("t5_commits", cmt_n, 0);
        chk("t5_err", err_cnt, 4);

        // Asynchronous reset mid-TLP
        clr();
        sym(T_STP, 8'hFB, 2'b01);
        data(7, 2'b01);
        chk("t6_pre_wr", buf_wr_en, 1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_wr", buf_wr_en, 0);
        chk("t6_async_ctx", ctx_q, 0);
        chk("t6_async_err", err_cnt, 0);
        chk("t6_async_discard", buf_discard, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        sym(T_STP, 8'hFB, 2'b01);
        data(18, 2'b01);
        sym(T_TEND, 8'hFD, 2'b00);
        chk("t6_commit", buf_commit, 1);
        chk("t6_len", pkt_len, 18);
        chk("t6_wr_count", wr_n, 18);
        pkt_ready = 1'b1;
        idle();
        pkt_ready = 1'b0;

        // Error counter saturation
        clr();
        for (int i = 0; i < 260; i++) sym(T_TEND, 8'hFD, 2'b00);
        chk("sat_pulses", errp_n, 260);
        chk("sat_cnt", err_cnt, 255);
        chk("never_both", both_n, 0);

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
